// File: rtl/sm4_stream_engine.sv
// sm4_stream_engine
// Streaming SM4 block cipher. A key is expanded once into a 32-entry round-key
// file, then any number of 128-bit blocks are pushed through it in ECB or CBC
// mode, encrypt or decrypt. rounds_per_cycle_p (1, 2, 4 or 8) unrolls the round
// function, so key expansion and each block pass take 32/R cycles.
//
// Ports
//   clk_i, reset_i  clock, synchronous active-high reset
//   key_i, iv_i     cipher key and CBC initial vector, latched on key load
//   decode_i, cbc_i 1=decrypt / 1=CBC, latched on key load
//   key_v_i         key-load request, taken when key_ready_o
//   key_ready_o     engine idle (no key yet, or between blocks)
//   data_i, v_i     input block and valid, taken when ready_o
//   ready_o         engine keyed and waiting for a block
//   data_o, v_o     result block and valid, data_o stable while v_o
//   yumi_i          consumer takes data_o
//   keyed_o         a fully expanded key is in use
module sm4_stream_engine #(
  parameter int rounds_per_cycle_p = 1,
  localparam int group_size_p = 128,
  localparam int word_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [group_size_p-1:0] key_i,
  input  logic [group_size_p-1:0] iv_i,
  input  logic                    decode_i,
  input  logic                    cbc_i,
  input  logic                    key_v_i,
  output logic                    key_ready_o,
  input  logic [group_size_p-1:0] data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [group_size_p-1:0] data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic                    keyed_o
);

  localparam logic [4:0] step_c = 5'(rounds_per_cycle_p);
  localparam logic [4:0] last_c = 5'(32 - rounds_per_cycle_p);
  localparam logic [127:0] fk_c = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  localparam logic [7:0] sbox_c [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  typedef enum logic [2:0] {eIdle, eKeyExp, eWait, eCrypt, eReverse, eDone} state_e;

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {sbox_c[a[31:24]], sbox_c[a[23:16]], sbox_c[a[15:8]], sbox_c[a[7:0]]};
  endfunction

  function automatic logic [31:0] t_round(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  // CK[i] byte j is (4i+j)*7 mod 256, so it is generated instead of stored.
  function automatic logic [31:0] ck(input logic [4:0] i);
    logic [7:0]  base;
    logic [31:0] r;
    r = '0;
    base = {1'b0, i, 2'b00};
    for (int j = 0; j < 4; j++) r[31-8*j -: 8] = (base + 8'(j)) * 8'd7;
    return r;
  endfunction

  state_e                     state_q, state_n;
  logic [4:0]                 cnt_q;
  logic [group_size_p-1:0]    key_q, x_q, chain_q, cin_q, data_q;
  logic                       decode_q, cbc_q, keyed_q;
  logic [word_width_p-1:0]    rk_file [32];
  logic [group_size_p-1:0]    kw_next, xw_next, result;
  logic [word_width_p-1:0]    new_rk [rounds_per_cycle_p];

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= eIdle;
    else         state_q <= state_n;
  end

  // A key request in eWait wins over a block in the same cycle.
  always_comb begin
    state_n     = state_q;
    key_ready_o = 1'b0;
    ready_o     = 1'b0;
    v_o         = 1'b0;
    unique case (state_q)
      eIdle: begin
        key_ready_o = 1'b1;
        if (key_v_i) state_n = eKeyExp;
      end
      eKeyExp: if (cnt_q == last_c) state_n = eWait;
      eWait: begin
        key_ready_o = 1'b1;
        ready_o     = 1'b1;
        if (key_v_i)  state_n = eKeyExp;
        else if (v_i) state_n = eCrypt;
      end
      eCrypt:   if (cnt_q == last_c) state_n = eReverse;
      eReverse: state_n = eDone;
      eDone: begin
        v_o = 1'b1;
        if (yumi_i) state_n = eWait;
      end
      default: state_n = eIdle;
    endcase
  end

  // Unrolled key-schedule and cipher rounds. The working registers shift left one
  // word per round, so after 32 rounds x_q holds {X32,X33,X34,X35}.
  always_comb begin
    logic [4:0] ri;
    ri      = '0;
    kw_next = key_q;
    xw_next = x_q;
    for (int j = 0; j < rounds_per_cycle_p; j++) begin
      new_rk[j] = kw_next[127:96] ^ t_key(kw_next[95:64] ^ kw_next[63:32] ^ kw_next[31:0]
                                          ^ ck(cnt_q + 5'(j)));
      kw_next   = {kw_next[95:0], new_rk[j]};
      ri        = cnt_q + 5'(j);
      if (decode_q) ri = 5'd31 - ri;
      xw_next   = {xw_next[95:0], xw_next[127:96] ^ t_round(xw_next[95:64] ^ xw_next[63:32]
                                                            ^ xw_next[31:0] ^ rk_file[ri])};
    end
    result = {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]}
             ^ ((cbc_q && decode_q) ? chain_q : '0);
  end

  // Datapath registers. The chain always tracks the last ciphertext so CBC can
  // continue across blocks until the next key load resets it to the new IV.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      key_q    <= '0;
      x_q      <= '0;
      chain_q  <= '0;
      cin_q    <= '0;
      data_q   <= '0;
      decode_q <= 1'b0;
      cbc_q    <= 1'b0;
      keyed_q  <= 1'b0;
      for (int i = 0; i < 32; i++) rk_file[i] <= '0;
    end else begin
      unique case (state_q)
        eIdle, eWait: begin
          if (key_v_i) begin
            key_q    <= key_i ^ fk_c;
            chain_q  <= iv_i;
            decode_q <= decode_i;
            cbc_q    <= cbc_i;
            keyed_q  <= 1'b0;
            cnt_q    <= '0;
          end else if (state_q == eWait && v_i) begin
            x_q   <= (cbc_q && !decode_q) ? (data_i ^ chain_q) : data_i;
            cin_q <= data_i;
            cnt_q <= '0;
          end
        end
        eKeyExp: begin
          for (int j = 0; j < rounds_per_cycle_p; j++) rk_file[cnt_q + 5'(j)] <= new_rk[j];
          key_q <= kw_next;
          cnt_q <= cnt_q + step_c;
          if (cnt_q == last_c) keyed_q <= 1'b1;
        end
        eCrypt: begin
          x_q   <= xw_next;
          cnt_q <= cnt_q + step_c;
        end
        eReverse: begin
          data_q  <= result;
          chain_q <= decode_q ? cin_q : result;
        end
        default: ;
      endcase
    end
  end

  assign data_o  = data_q;
  assign keyed_o = keyed_q;

endmodule

// File: tb/tb_sm4_stream_engine.sv
// tb_sm4_stream_engine
// Directed bench for sm4_stream_engine. The main instance runs at one round per
// cycle; three more instances at 2, 4 and 8 rounds per cycle share the inputs and
// are used for the latency-versus-unroll check. Expected values come from the
// published SM4 test vector and a plain software reference model below.
module tb_sm4_stream_engine;

  localparam logic [127:0] pt_c  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] ct_c  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] key2_c = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] pt2_c = 128'hdeadbeef_cafef00d_01020304_a5a5a5a5;

  localparam logic [7:0] sb_c [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  logic         clk = 1'b0;
  logic         reset, decode, cbc, key_v, v_in, yumi;
  logic [127:0] key, iv, data_in;
  logic         key_ready1, ready1, v_o1, keyed1;
  logic         key_ready2, ready2, v_o2, keyed2;
  logic         key_ready4, ready4, v_o4, keyed4;
  logic         key_ready8, ready8, v_o8, keyed8;
  logic [127:0] data_o1, data_o2, data_o4, data_o8;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  sm4_stream_engine #(.rounds_per_cycle_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .key_i(key), .iv_i(iv), .decode_i(decode), .cbc_i(cbc),
    .key_v_i(key_v), .key_ready_o(key_ready1), .data_i(data_in), .v_i(v_in), .ready_o(ready1),
    .data_o(data_o1), .v_o(v_o1), .yumi_i(yumi), .keyed_o(keyed1));
  sm4_stream_engine #(.rounds_per_cycle_p(2)) dut2 (
    .clk_i(clk), .reset_i(reset), .key_i(key), .iv_i(iv), .decode_i(decode), .cbc_i(cbc),
    .key_v_i(key_v), .key_ready_o(key_ready2), .data_i(data_in), .v_i(v_in), .ready_o(ready2),
    .data_o(data_o2), .v_o(v_o2), .yumi_i(yumi), .keyed_o(keyed2));
  sm4_stream_engine #(.rounds_per_cycle_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .key_i(key), .iv_i(iv), .decode_i(decode), .cbc_i(cbc),
    .key_v_i(key_v), .key_ready_o(key_ready4), .data_i(data_in), .v_i(v_in), .ready_o(ready4),
    .data_o(data_o4), .v_o(v_o4), .yumi_i(yumi), .keyed_o(keyed4));
  sm4_stream_engine #(.rounds_per_cycle_p(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .key_i(key), .iv_i(iv), .decode_i(decode), .cbc_i(cbc),
    .key_v_i(key_v), .key_ready_o(key_ready8), .data_i(data_in), .v_i(v_in), .ready_o(ready8),
    .data_o(data_o8), .v_o(v_o8), .yumi_i(yumi), .keyed_o(keyed8));

  // Software reference: full key schedule first, then 32 rounds, word reverse.
  function automatic logic [31:0] sb32(input logic [31:0] a);
    return {sb_c[a[31:24]], sb_c[a[23:16]], sb_c[a[15:8]], sb_c[a[7:0]]};
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] sm4_ref(input logic [127:0] k_in, input logic [127:0] blk,
                                           input bit dec);
    logic [31:0]  k [36];
    logic [31:0]  rk [32];
    logic [31:0]  x [36];
    logic [31:0]  t, ckw;
    logic [127:0] fk;
    fk = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
    for (int i = 0; i < 4; i++) begin
      k[i] = k_in[127-32*i -: 32] ^ fk[127-32*i -: 32];
      x[i] = blk[127-32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      ckw = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
      t = sb32(k[i+1] ^ k[i+2] ^ k[i+3] ^ ckw);
      k[i+4] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
      rk[i] = k[i+4];
    end
    for (int i = 0; i < 32; i++) begin
      t = sb32(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rk[31-i] : rk[i]));
      x[i+4] = x[i] ^ t ^ rotl(t, 2) ^ rotl(t, 10) ^ rotl(t, 18) ^ rotl(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // Stimulus helpers; all driving and sampling happens 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1; key_v = 1'b0; v_in = 1'b0; yumi = 1'b0;
    key = '0; iv = '0; data_in = '0; decode = 1'b0; cbc = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k, input logic [127:0] ivv, input bit dec,
                          input bit cb, output int n);
    key = k; iv = ivv; decode = dec; cbc = cb; key_v = 1'b1;
    @(posedge clk);
    #1 key_v = 1'b0;
    n = 0;
    while (keyed1 !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic send_block(input logic [127:0] blk, output bit acc, output int lat);
    data_in = blk; v_in = 1'b1;
    acc = ready1;
    @(posedge clk);
    #1 v_in = 1'b0;
    lat = 0;
    while (v_o1 !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic take_block();
    yumi = 1'b1;
    @(posedge clk);
    #1 yumi = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (key_ready1 !== 1'b1) begin bad++; $display("FAIL reset_key_ready got=%b want=1", key_ready1); end
    total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready1); end
    total++; if (v_o1 !== 1'b0) begin bad++; $display("FAIL reset_v_o got=%b want=0", v_o1); end
    total++; if (keyed1 !== 1'b0) begin bad++; $display("FAIL reset_keyed got=%b want=0", keyed1); end
    total++; if (data_o1 !== 128'h0) begin bad++; $display("FAIL reset_data_o got=%h want=0", data_o1); end
    data_in = pt_c; v_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 v_in = 1'b0;
    total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b want=0", ready1); end
    total++; if (key_ready1 !== 1'b1) begin bad++; $display("FAIL idle_key_ready got=%b want=1", key_ready1); end
    total++; if (v_o1 !== 1'b0) begin bad++; $display("FAIL idle_v_o got=%b want=0", v_o1); end
  endtask

  task automatic test_ecb_enc();
    int n, lat;
    bit acc;
    load_key(pt_c, '0, 1'b0, 1'b0, n);
    total++; if (n != 32) begin bad++; $display("FAIL keyexp_cycles got=%0d want=32", n); end
    total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL keyed_ready got=%b want=1", ready1); end
    send_block(pt_c, acc, lat);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL ecb_enc_accept got=%b want=1", acc); end
    total++; if (lat != 33) begin bad++; $display("FAIL ecb_enc_latency got=%0d want=33", lat); end
    total++; if (data_o1 !== ct_c) begin bad++; $display("FAIL ecb_enc_data got=%h want=%h", data_o1, ct_c); end
    take_block();
  endtask

  task automatic test_ecb_dec();
    int n, lat;
    bit acc;
    load_key(pt_c, '0, 1'b1, 1'b0, n);
    send_block(ct_c, acc, lat);
    total++; if (lat != 33) begin bad++; $display("FAIL ecb_dec_latency got=%0d want=33", lat); end
    total++; if (data_o1 !== pt_c) begin bad++; $display("FAIL ecb_dec_data got=%h want=%h", data_o1, pt_c); end
    take_block();
  endtask

  task automatic test_cbc();
    int n, lat;
    bit acc;
    logic [127:0] c2;
    c2 = sm4_ref(pt_c, ct_c ^ pt_c, 1'b0);
    load_key(pt_c, '0, 1'b0, 1'b1, n);
    send_block(pt_c, acc, lat);
    total++; if (data_o1 !== ct_c) begin bad++; $display("FAIL cbc_enc_blk1 got=%h want=%h", data_o1, ct_c); end
    take_block();
    send_block(pt_c, acc, lat);
    total++; if (data_o1 !== c2) begin bad++; $display("FAIL cbc_enc_blk2 got=%h want=%h", data_o1, c2); end
    take_block();
    load_key(pt_c, '0, 1'b1, 1'b1, n);
    send_block(ct_c, acc, lat);
    total++; if (data_o1 !== pt_c) begin bad++; $display("FAIL cbc_dec_blk1 got=%h want=%h", data_o1, pt_c); end
    take_block();
    send_block(c2, acc, lat);
    total++; if (data_o1 !== pt_c) begin bad++; $display("FAIL cbc_dec_blk2 got=%h want=%h", data_o1, pt_c); end
    take_block();
  endtask

  task automatic test_backpressure();
    int n, lat;
    bit acc;
    logic [127:0] exp1, exp2;
    exp1 = sm4_ref(key2_c, pt2_c, 1'b0);
    exp2 = sm4_ref(key2_c, ~pt2_c, 1'b0);
    load_key(key2_c, '0, 1'b0, 1'b0, n);
    send_block(pt2_c, acc, lat);
    data_in = ~pt2_c; v_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      total++; if (data_o1 !== exp1) begin bad++; $display("FAIL bp_data c=%0d got=%h want=%h", c, data_o1, exp1); end
      total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL bp_ready c=%0d got=%b want=0", c, ready1); end
      total++; if (v_o1 !== 1'b1) begin bad++; $display("FAIL bp_v_o c=%0d got=%b want=1", c, v_o1); end
    end
    v_in = 1'b0;
    take_block();
    total++; if (v_o1 !== 1'b0) begin bad++; $display("FAIL bp_after_yumi_v_o got=%b want=0", v_o1); end
    total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL bp_after_yumi_ready got=%b want=1", ready1); end
    send_block(~pt2_c, acc, lat);
    total++; if (data_o1 !== exp2) begin bad++; $display("FAIL bp_next_data got=%h want=%h", data_o1, exp2); end
    take_block();
  endtask

  task automatic test_key_priority();
    int n, lat;
    bit acc, saw_v;
    logic [127:0] exp;
    exp = sm4_ref(pt_c, pt2_c, 1'b0);
    key = pt_c; iv = '0; decode = 1'b0; cbc = 1'b0; key_v = 1'b1;
    data_in = pt2_c; v_in = 1'b1;
    @(posedge clk);
    #1 key_v = 1'b0; v_in = 1'b0;
    total++; if (keyed1 !== 1'b0) begin bad++; $display("FAIL prio_keyed got=%b want=0", keyed1); end
    total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL prio_ready got=%b want=0", ready1); end
    total++; if (key_ready1 !== 1'b0) begin bad++; $display("FAIL prio_key_ready got=%b want=0", key_ready1); end
    n = 0;
    saw_v = 1'b0;
    while (keyed1 !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1 n++;
      if (v_o1 === 1'b1) saw_v = 1'b1;
    end
    total++; if (n != 32) begin bad++; $display("FAIL prio_keyed_gap got=%0d want=32", n); end
    total++; if (saw_v !== 1'b0) begin bad++; $display("FAIL prio_block_taken got=%b want=0", saw_v); end
    send_block(pt2_c, acc, lat);
    total++; if (data_o1 !== exp) begin bad++; $display("FAIL prio_data got=%h want=%h", data_o1, exp); end
    take_block();
  endtask

  task automatic test_reset_mid();
    int n, lat;
    bit acc;
    logic [127:0] exp;
    exp = sm4_ref(key2_c, pt2_c, 1'b0);
    data_in = pt_c; v_in = 1'b1;
    @(posedge clk);
    #1 v_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    total++; if (v_o1 !== 1'b0) begin bad++; $display("FAIL midrst_v_o got=%b want=0", v_o1); end
    total++; if (key_ready1 !== 1'b1) begin bad++; $display("FAIL midrst_key_ready got=%b want=1", key_ready1); end
    total++; if (keyed1 !== 1'b0) begin bad++; $display("FAIL midrst_keyed got=%b want=0", keyed1); end
    total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b want=0", ready1); end
    load_key(key2_c, '0, 1'b0, 1'b0, n);
    send_block(pt2_c, acc, lat);
    total++; if (data_o1 !== exp) begin bad++; $display("FAIL midrst_data got=%h want=%h", data_o1, exp); end
    take_block();
  endtask

  task automatic test_rates();
    int n;
    int lat1, lat2, lat4, lat8;
    do_reset();
    load_key(pt_c, '0, 1'b1, 1'b0, n);
    total++; if ((keyed2 & keyed4 & keyed8) !== 1'b1) begin bad++; $display("FAIL rates_keyed got=%b%b%b want=111", keyed2, keyed4, keyed8); end
    data_in = ct_c; v_in = 1'b1;
    @(posedge clk);
    #1 v_in = 1'b0;
    lat1 = 0; lat2 = 0; lat4 = 0; lat8 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (v_o1 === 1'b1 && lat1 == 0) lat1 = c;
      if (v_o2 === 1'b1 && lat2 == 0) lat2 = c;
      if (v_o4 === 1'b1 && lat4 == 0) lat4 = c;
      if (v_o8 === 1'b1 && lat8 == 0) lat8 = c;
    end
    total++; if (lat1 != 33) begin bad++; $display("FAIL r1_latency got=%0d want=33", lat1); end
    total++; if (lat2 != 17) begin bad++; $display("FAIL r2_latency got=%0d want=17", lat2); end
    total++; if (lat4 != 9) begin bad++; $display("FAIL r4_latency got=%0d want=9", lat4); end
    total++; if (lat8 != 5) begin bad++; $display("FAIL r8_latency got=%0d want=5", lat8); end
    total++; if (data_o2 !== pt_c) begin bad++; $display("FAIL r2_data got=%h want=%h", data_o2, pt_c); end
    total++; if (data_o4 !== pt_c) begin bad++; $display("FAIL r4_data got=%h want=%h", data_o4, pt_c); end
    total++; if (data_o8 !== pt_c) begin bad++; $display("FAIL r8_data got=%h want=%h", data_o8, pt_c); end
    take_block();
  endtask

  initial begin
    test_reset();
    test_ecb_enc();
    test_ecb_dec();
    test_cbc();
    test_backpressure();
    test_key_priority();
    test_reset_mid();
    test_rates();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
